instr_encoder: RTL and testbench

//  Inverse of the control decoder: encodes a stream of symbolic instructions (op index + fields)

---
 rtl/instr_encoder.sv | 128 ++++++++++++
 tb/tb_instr_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Purpose : test-program loader. Encodes symbolic instruction beats (op index + fields)
//           into 32-bit MIPS words and writes them to consecutive IM word addresses.
// Latency : 1 cycle. A beat accepted at edge N drives im_we/im_addr/im_wdata for the cycle after N.
// Backpr. : valid/ready. in_ready is high only while a session runs (between start and done).
// Ports   : clk/reset (async, active-high); start/base_addr open a session; in_* beat stream;
//           im_we/im_addr/im_wdata registered IM write port; busy/done/count status;
//           err_op/err_full sticky per-session error flags.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_op,
  output logic              err_full
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0] MAX_CNT = MAX_WORDS[ADDR_W:0];

  logic [1:0]        state;
  logic [ADDR_W-1:0] wptr;
  logic [31:0]       enc_word;
  logic [ADDR_W:0]   count_next;
  logic              accept;
  logic              op_ok;
  logic              full_hit;

  assign in_ready   = (state == S_RUN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign accept     = in_valid & in_ready;
  assign op_ok      = (in_op < 4'd12);
  assign count_next = count + 1'b1;
  assign full_hit   = (count_next == MAX_CNT);

  // Fields an opcode does not use are forced to zero so stray bench/host
  // values never leak into the emitted word.
  always_comb begin
    enc_word = 32'h0;
    case (in_op)
      4'd0:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};      // ADDU
      4'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};      // SUBU
      4'd2:  enc_word = {6'h0D, in_rs, in_rt, in_imm};                  // ORI
      4'd3:  enc_word = {6'h23, in_rs, in_rt, in_imm};                  // LW
      4'd4:  enc_word = {6'h2B, in_rs, in_rt, in_imm};                  // SW
      4'd5:  enc_word = {6'h04, in_rs, in_rt, in_imm};                  // BEQ
      4'd6:  enc_word = {6'h0F, 5'd0, in_rt, in_imm};                   // LUI
      4'd7:  enc_word = {6'h03, in_target};                             // JAL
      4'd8:  enc_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};        // JR
      4'd9:  enc_word = {6'h02, in_target};                             // J
      4'd10: enc_word = {6'h00, in_rs, 5'd0, in_rd, 5'd0, 6'h09};       // JALR
      4'd11: enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h03};   // SRA
      default: enc_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wptr     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'h0;
      count    <= '0;
      err_op   <= 1'b0;
      err_full <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            wptr     <= base_addr;
            count    <= '0;
            err_op   <= 1'b0;
            err_full <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (op_ok) begin
              im_we    <= 1'b1;
              im_addr  <= wptr;
              im_wdata <= enc_word;
              wptr     <= wptr + 1'b1;   // wraps silently at 2**ADDR_W
              count    <= count_next;
              if (in_last) begin
                state <= S_DONE;
              end else if (full_hit) begin
                err_full <= 1'b1;
                state    <= S_DONE;
              end
            end else begin
              // Illegal beat is consumed but produces no write.
              err_op <= 1'b1;
              if (in_last) state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: main instance at default size plus a
// MAX_WORDS=4 instance for the session-full boundary. Inputs are shared; each
// instance has its own start. Outputs are sampled 1 time unit after the edge.
module tb_instr_encoder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start4 = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_op = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          in_last = 1'b0;

  logic          in_ready, im_we, busy, done, err_op, err_full;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;

  logic          in_ready4, im_we4, busy4, done4, err_op4, err_full4;
  logic [AW-1:0] im_addr4;
  logic [31:0]   im_wdata4;
  logic [AW:0]   count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .busy(busy), .done(done), .count(count),
    .err_op(err_op), .err_full(err_full)
  );

  instr_encoder #(.ADDR_W(AW), .MAX_WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .im_we(im_we4), .im_addr(im_addr4),
    .im_wdata(im_wdata4), .busy(busy4), .done(done4), .count(count4),
    .err_op(err_op4), .err_full(err_full4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_session(input logic [AW-1:0] base, input logic which4);
    base_addr = base;
    if (which4) start4 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Presents one beat for exactly one edge; in_valid drops afterwards unless
  // the caller immediately presents another beat.
  task automatic beat(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, im_we}, 32'd1);
    chk({tag, "_addr"}, {22'd0, im_addr}, {22'd0, a});
    chk({tag, "_data"}, im_wdata, d);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_we", {31'd0, im_we}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {30'd0, err_op, err_full}, 32'd0);
    chk("rst_addr", {22'd0, im_addr}, 32'd0);
    chk("rst_data", im_wdata, 32'd0);
    chk("rst_count", {21'd0, count}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: single ADDU with last
    open_session(10'd0, 1'b0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    beat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    chk_wr("t1", 10'd0, 32'h00221821);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_count", {21'd0, count}, 32'd1);
    chk("t1_ready_off", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_idle_done", {31'd0, done}, 32'd0);
    chk("t1_idle_we", {31'd0, im_we}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: back-to-back burst
    open_session(10'd0, 1'b0);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    chk_wr("t2_ori", 10'd0, 32'h34011234);
    beat(4'd6, 5'd0, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    chk_wr("t2_lui", 10'd1, 32'h3C02FFFF);
    beat(4'd4, 5'd29, 5'd5, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b0);
    chk_wr("t2_sw", 10'd2, 32'hAFA5FFFC);
    beat(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b1);
    chk_wr("t2_beq", 10'd3, 32'h10220003);
    chk("t2_count", {21'd0, count}, 32'd4);
    tick();

    // 3: unused fields carry junk
    open_session(10'd16, 1'b0);
    beat(4'd11, 5'd12, 5'd5, 5'd4, 5'd2, 16'hBEEF, 26'h3FFFFFF, 1'b0);
    chk_wr("t3_sra", 10'd16, 32'h00052083);
    beat(4'd8, 5'd31, 5'd7, 5'd9, 5'd3, 16'hFFFF, 26'h1555555, 1'b0);
    chk_wr("t3_jr", 10'd17, 32'h03E00008);
    beat(4'd7, 5'd17, 5'd18, 5'd19, 5'd20, 16'hAAAA, 26'h0000C03, 1'b1);
    chk_wr("t3_jal", 10'd18, 32'h0C000C03);
    tick();

    // 4: illegal op mid-stream
    open_session(10'd32, 1'b0);
    chk("t4_err_clr", {31'd0, err_op}, 32'd0);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0, 1'b0);
    chk_wr("t4_first", 10'd32, 32'h34010001);
    beat(4'd13, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, 1'b0);
    chk("t4_ill_we", {31'd0, im_we}, 32'd0);
    chk("t4_ill_err", {31'd0, err_op}, 32'd1);
    chk("t4_ill_count", {21'd0, count}, 32'd1);
    chk("t4_hold_addr", {22'd0, im_addr}, 32'd32);
    beat(4'd2, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0002, 26'h0, 1'b1);
    chk_wr("t4_next", 10'd33, 32'h34020002);
    chk("t4_count", {21'd0, count}, 32'd2);
    chk("t4_err_sticky", {31'd0, err_op}, 32'd1);
    tick();

    // 5: MAX_WORDS=4 instance, base at top of IM, six beats, no last
    open_session(10'd1023, 1'b1);
    chk("t5_main_idle", {31'd0, in_ready}, 32'd0);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
    chk("t5_w0_addr", {22'd0, im_addr4}, 32'd1023);
    chk("t5_w0_we", {31'd0, im_we4}, 32'd1);
    chk("t5_main_nowe", {31'd0, im_we}, 32'd0);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0011, 26'h0, 1'b0);
    chk("t5_w1_addr", {22'd0, im_addr4}, 32'd0);
    chk("t5_w1_data", im_wdata4, 32'h34010011);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0012, 26'h0, 1'b0);
    chk("t5_w2_addr", {22'd0, im_addr4}, 32'd1);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0013, 26'h0, 1'b0);
    chk("t5_w3_addr", {22'd0, im_addr4}, 32'd2);
    chk("t5_w3_we", {31'd0, im_we4}, 32'd1);
    chk("t5_err_full", {31'd0, err_full4}, 32'd1);
    chk("t5_done", {31'd0, done4}, 32'd1);
    chk("t5_ready_off", {31'd0, in_ready4}, 32'd0);
    chk("t5_count", {21'd0, count4}, 32'd4);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0014, 26'h0, 1'b0);
    chk("t5_b5_we", {31'd0, im_we4}, 32'd0);
    beat(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0015, 26'h0, 1'b0);
    chk("t5_b6_we", {31'd0, im_we4}, 32'd0);
    chk("t5_count_hold", {21'd0, count4}, 32'd4);

    // 6a: ignored start while RUN, stalls produce no writes
    open_session(10'd200, 1'b0);
    beat(4'd2, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0020, 26'h0, 1'b0);
    chk_wr("t6_w0", 10'd200, 32'h34030020);
    open_session(10'd300, 1'b0);
    chk("t6_start_we", {31'd0, im_we}, 32'd0);
    tick();
    chk("t6_stall_we", {31'd0, im_we}, 32'd0);
    beat(4'd2, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0021, 26'h0, 1'b0);
    chk_wr("t6_w1", 10'd201, 32'h34030021);
    chk("t6_count", {21'd0, count}, 32'd2);

    // 6b: reset in the middle of a burst
    beat(4'd2, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0022, 26'h0, 1'b0);
    chk("t6_pre_rst_we", {31'd0, im_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_we", {31'd0, im_we}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_addr", {22'd0, im_addr}, 32'd0);
    chk("t6_rst_data", im_wdata, 32'd0);
    chk("t6_rst_count", {21'd0, count}, 32'd0);
    tick();
    reset = 1'b0;
    beat(4'd2, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0023, 26'h0, 1'b0);
    chk("t6_no_resume", {31'd0, im_we}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
